// File: rtl/fifo_pkt_writer.sv
// ---------------------------------------------------------------------------
// fifo_pkt_writer
//
// Write-side packet framer for the dual-clock FIFO, running only in the w_clk
// domain. Each packet goes into the FIFO as:
//    header (pkt_len zero-extended), N payload words, checksum trailer.
// The trailer is the two's complement of the payload sum, so the payload
// words plus the trailer add up to 0 mod 2^DATA_WIDTH.
//
// Ports
//    w_clk      write-domain clock, rising edge
//    rst        asynchronous, active-low reset
//    start      packet request, sampled only in IDLE
//    pkt_len    payload word count, sampled with start (0 is rejected)
//    s_valid    upstream payload word valid
//    s_data     upstream payload word
//    s_ready    payload word accepted when s_valid && s_ready
//    fifo_full  FIFO full flag (w_clk domain)
//    fifo_we    FIFO write enable, never high while fifo_full is high
//    fifo_din   FIFO write data
//    busy       high while a packet is being emitted (HDR/PAY/TRL)
//    done       one-cycle pulse in the first IDLE cycle after the trailer
//    err_len    one-cycle pulse after a start with pkt_len == 0
//    pkt_count  completed packets, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module fifo_pkt_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  w_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic                  fifo_full,
   output logic                  fifo_we,
   output logic [DATA_WIDTH-1:0] fifo_din,
   output logic                  busy,
   output logic                  done,
   output logic                  err_len,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_TRL  = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  len_s;
   logic [LEN_WIDTH-1:0]  remaining_r;
   logic [LEN_WIDTH-1:0]  remaining_s;
   logic [DATA_WIDTH-1:0] checksum_r;
   logic [DATA_WIDTH-1:0] checksum_s;
   logic [CNT_WIDTH-1:0]  pkt_count_r;
   logic [CNT_WIDTH-1:0]  pkt_count_s;
   logic                  done_r;
   logic                  done_s;
   logic                  err_len_r;
   logic                  err_len_s;

   // Running payload sum, modulo 2^DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] csum_add(
      input logic [DATA_WIDTH-1:0] acc,
      input logic [DATA_WIDTH-1:0] word
   );
      return acc + word;
   endfunction

   // Trailer value: two's complement of the payload sum.
   function automatic logic [DATA_WIDTH-1:0] csum_trailer(
      input logic [DATA_WIDTH-1:0] acc
   );
      return (~acc) + DATA_WIDTH'(1'b1);
   endfunction

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge w_clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         len_r       <= '0;
         remaining_r <= '0;
         checksum_r  <= '0;
         pkt_count_r <= '0;
         done_r      <= 1'b0;
         err_len_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         len_r       <= len_s;
         remaining_r <= remaining_s;
         checksum_r  <= checksum_s;
         pkt_count_r <= pkt_count_s;
         done_r      <= done_s;
         err_len_r   <= err_len_s;
      end
   end

   // Next-state logic and FIFO/upstream handshake outputs.
   always_comb begin
      state_s     = state_r;
      len_s       = len_r;
      remaining_s = remaining_r;
      checksum_s  = checksum_r;
      pkt_count_s = pkt_count_r;
      done_s      = 1'b0;
      err_len_s   = 1'b0;
      fifo_we     = 1'b0;
      fifo_din    = '0;
      s_ready     = 1'b0;
      busy        = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (pkt_len != '0) begin
                  len_s       = pkt_len;
                  remaining_s = pkt_len;
                  checksum_s  = '0;
                  state_s     = ST_HDR;
               end else begin
                  err_len_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_HDR: begin
            busy     = 1'b1;
            fifo_din = DATA_WIDTH'(len_r);
            fifo_we  = !fifo_full;
            if (!fifo_full) begin
               state_s = ST_PAY;
            end else begin
               state_s = ST_HDR;
            end
         end

         ST_PAY: begin
            // Zero-latency pass-through: the accepted word goes straight
            // onto the FIFO port in the same cycle.
            busy     = 1'b1;
            s_ready  = !fifo_full;
            fifo_din = s_data;
            fifo_we  = s_valid && !fifo_full;
            if (s_valid && !fifo_full) begin
               checksum_s  = csum_add(checksum_r, s_data);
               remaining_s = remaining_r - LEN_WIDTH'(1'b1);
               if (remaining_r == LEN_WIDTH'(1'b1)) begin
                  state_s = ST_TRL;
               end else begin
                  state_s = ST_PAY;
               end
            end else begin
               state_s = ST_PAY;
            end
         end

         ST_TRL: begin
            busy     = 1'b1;
            fifo_din = csum_trailer(checksum_r);
            fifo_we  = !fifo_full;
            if (!fifo_full) begin
               state_s     = ST_IDLE;
               pkt_count_s = pkt_count_r + CNT_WIDTH'(1'b1);
               done_s      = 1'b1;
            end else begin
               state_s = ST_TRL;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign done      = done_r;
   assign err_len   = err_len_r;
   assign pkt_count = pkt_count_r;

   fifo_pkt_writer_chk u_chk (
      .w_clk     (w_clk),
      .rst       (rst),
      .fifo_full (fifo_full),
      .fifo_we   (fifo_we),
      .s_ready   (s_ready),
      .done      (done),
      .err_len   (err_len)
   );

endmodule

// ---------------------------------------------------------------------------
// fifo_pkt_writer_chk
//
// Protocol properties of the packet writer's external interface.
// Ports: w_clk, rst, fifo_full, fifo_we, s_ready, done, err_len (all inputs).
// ---------------------------------------------------------------------------
module fifo_pkt_writer_chk (
   input logic w_clk,
   input logic rst,
   input logic fifo_full,
   input logic fifo_we,
   input logic s_ready,
   input logic done,
   input logic err_len
);

   // A full FIFO must never see a write.
   a_no_write_when_full: assert property (@(posedge w_clk) disable iff (!rst)
      fifo_full |-> !fifo_we);

   // No payload word is accepted while the FIFO is full.
   a_no_ready_when_full: assert property (@(posedge w_clk) disable iff (!rst)
      fifo_full |-> !s_ready);

   // done is a single-cycle pulse.
   a_done_pulse: assert property (@(posedge w_clk) disable iff (!rst)
      done |=> !done);

   // A completed packet and a rejected request cannot report together.
   a_done_err_excl: assert property (@(posedge w_clk) disable iff (!rst)
      !(done && err_len));

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_pkt_writer
//
// Drives fifo_pkt_writer with directed packets followed by random traffic.
// A packet-level model (position within the current packet, running sum)
// predicts the outputs on every cycle; directed packets are also compared
// word-for-word against hand-computed FIFO contents.
// The counter width is reduced to 6 so the wrap can be exercised quickly.
// ---------------------------------------------------------------------------
module tb_fifo_pkt_writer;

   localparam int DW   = 8;
   localparam int LW   = 8;
   localparam int CW   = 6;
   localparam int MASK = (1 << DW) - 1;
   localparam int CMOD = (1 << CW);

   logic          w_clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          fifo_full = 1'b0;
   logic          fifo_we;
   logic [DW-1:0] fifo_din;
   logic          busy;
   logic          done;
   logic          err_len;
   logic [CW-1:0] pkt_count;

   int total = 0;
   int bad   = 0;

   always #5 w_clk = ~w_clk;

   fifo_pkt_writer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .w_clk     (w_clk),
      .rst       (rst),
      .start     (start),
      .pkt_len   (pkt_len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .fifo_full (fifo_full),
      .fifo_we   (fifo_we),
      .fifo_din  (fifo_din),
      .busy      (busy),
      .done      (done),
      .err_len   (err_len),
      .pkt_count (pkt_count)
   );

   // model state: active packet, position (0 = header, 1..len = payload,
   // len+1 = trailer), running payload sum, completed count, pending pulses
   bit  m_active;
   int  m_pos, m_len, m_sum, m_count;
   bit  m_done, m_err;

   logic [DW-1:0] wr_log[$];
   int            done_seen = 0;
   int            err_seen  = 0;

   logic [DW-1:0] pay[$];
   int            pidx = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the packet-level model.
   initial begin : cmp
      int e_we, e_rdy, e_din;
      bit nd, ne;
      forever begin
         @(negedge w_clk);
         if (!rst) begin
            m_active = 1'b0; m_pos = 0; m_len = 0; m_sum = 0; m_count = 0;
            m_done = 1'b0; m_err = 1'b0;
            chk("rst_we",    fifo_we,   0);
            chk("rst_din",   fifo_din,  0);
            chk("rst_ready", s_ready,   0);
            chk("rst_busy",  busy,      0);
            chk("rst_done",  done,      0);
            chk("rst_err",   err_len,   0);
            chk("rst_count", pkt_count, 0);
         end else begin
            e_we = 0; e_rdy = 0; e_din = 0;
            if (m_active) begin
               if (m_pos == 0) begin
                  e_we = !fifo_full; e_din = m_len;
               end else if (m_pos <= m_len) begin
                  e_rdy = !fifo_full; e_we = s_valid && !fifo_full; e_din = s_data;
               end else begin
                  e_we = !fifo_full; e_din = (-m_sum) & MASK;
               end
            end
            chk("we",    fifo_we,   e_we);
            chk("din",   fifo_din,  e_din);
            chk("ready", s_ready,   e_rdy);
            chk("busy",  busy,      m_active);
            chk("done",  done,      m_done);
            chk("err",   err_len,   m_err);
            chk("count", pkt_count, m_count);
            if (fifo_we === 1'b1) wr_log.push_back(fifo_din);
            if (done === 1'b1) done_seen++;
            if (err_len === 1'b1) err_seen++;

            nd = m_active && (m_pos == m_len + 1) && !fifo_full;
            ne = !m_active && start && (pkt_len == 0);
            if (!m_active) begin
               if (start && pkt_len != 0) begin
                  m_active = 1'b1; m_pos = 0; m_len = pkt_len; m_sum = 0;
               end
            end else if (e_we != 0) begin
               if (m_pos >= 1 && m_pos <= m_len) m_sum = (m_sum + s_data) & MASK;
               if (m_pos == m_len + 1) begin
                  m_active = 1'b0;
                  m_count  = (m_count + 1) % CMOD;
               end else begin
                  m_pos++;
               end
            end
            m_done = nd;
            m_err  = ne;
         end
      end
   end

   // One clock cycle; advances the payload source on a handshake.
   task automatic step();
      bit acc;
      @(negedge w_clk);
      acc = (s_valid === 1'b1) && (s_ready === 1'b1) && rst;
      @(posedge w_clk);
      #1;
      if (acc) pidx++;
      if (pidx < pay.size()) s_data = pay[pidx];
   endtask

   task automatic set_pay(input logic [DW-1:0] p[$]);
      pay = p;
      pidx = 0;
      if (pay.size() > 0) s_data = pay[0];
   endtask

   task automatic chk_log(input string name, input logic [DW-1:0] exp[$]);
      chk({name, "_len"}, wr_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
         chk(name, wr_log[i], exp[i]);
   endtask

   task automatic idle(input int n);
      start = 1'b0; s_valid = 1'b0; fifo_full = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0, e0, c;
      #1 rst = 1'b0;
      @(posedge w_clk); #1;
      @(posedge w_clk); #1;
      rst = 1'b1;
      idle(2);

      // basic packet
      wr_log.delete();
      set_pay('{8'h10, 8'h20, 8'h30});
      d0 = done_seen;
      for (c = 0; c < 40 && done_seen == d0; c++) begin
         start = (c == 0); pkt_len = 8'd3; s_valid = 1'b1; fifo_full = 1'b0;
         step();
      end
      chk("basic_done", done_seen - d0, 1);
      idle(2);
      chk_log("basic", '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0});
      chk("basic_count", pkt_count, 1);

      // FIFO backpressure in HDR and mid-PAY
      wr_log.delete();
      set_pay('{8'h10, 8'h20, 8'h30});
      d0 = done_seen;
      for (c = 0; c < 40 && done_seen == d0; c++) begin
         start = (c == 0); pkt_len = 8'd3; s_valid = 1'b1;
         fifo_full = ((c >= 1 && c <= 4) || (c >= 7 && c <= 8));
         step();
      end
      chk("bp_done", done_seen - d0, 1);
      idle(2);
      chk_log("bp", '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0});
      chk("bp_count", pkt_count, 2);

      // upstream stall, checksum wraps to zero
      wr_log.delete();
      set_pay('{8'hFF, 8'h01});
      d0 = done_seen;
      for (c = 0; c < 40 && done_seen == d0; c++) begin
         start = (c == 0); pkt_len = 8'd2; fifo_full = 1'b0;
         s_valid = !(c >= 3 && c <= 5);
         step();
      end
      chk("stall_done", done_seen - d0, 1);
      idle(2);
      chk_log("stall", '{8'h02, 8'hFF, 8'h01, 8'h00});

      // zero length request
      wr_log.delete();
      e0 = err_seen;
      start = 1'b1; pkt_len = 8'd0; s_valid = 1'b0;
      step();
      idle(3);
      chk("zero_err", err_seen - e0, 1);
      chk("zero_nowrite", wr_log.size(), 0);

      // start while busy is ignored
      set_pay('{8'h01, 8'h02, 8'h03, 8'h04});
      d0 = done_seen;
      for (c = 0; c < 40 && done_seen == d0; c++) begin
         start = (c == 0 || c == 3); pkt_len = (c == 0) ? 8'd4 : 8'd9;
         s_valid = 1'b1; fifo_full = 1'b0;
         step();
      end
      chk("busy_done", done_seen - d0, 1);
      idle(3);
      chk_log("busy", '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6});

      // back-to-back with start held, counter wraps
      wr_log.delete();
      pay.delete(); pidx = 0; s_data = 8'h05;
      d0 = done_seen;
      for (c = 0; c < 320 && (done_seen - d0) < 70; c++) begin
         start = (c < 280); pkt_len = 8'd1; s_valid = 1'b1; fifo_full = 1'b0;
         step();
      end
      chk("b2b_done", done_seen - d0, 70);
      chk("b2b_cycles", c, 281);
      idle(2);
      chk("b2b_words", wr_log.size(), 210);
      for (int i = 0; i < wr_log.size(); i++) begin
         if (i % 3 == 0)      chk("b2b_hdr", wr_log[i], 8'h01);
         else if (i % 3 == 1) chk("b2b_pay", wr_log[i], 8'h05);
         else                 chk("b2b_trl", wr_log[i], 8'hFB);
      end
      chk("b2b_count", pkt_count, (4 + 70) % CMOD);

      // reset mid-packet
      wr_log.delete();
      set_pay('{8'h11, 8'h22, 8'h33, 8'h44});
      for (c = 0; c < 4; c++) begin
         start = (c == 0); pkt_len = 8'd4; s_valid = 1'b1; fifo_full = 1'b0;
         step();
      end
      rst = 1'b0;
      #1;
      chk("mid_rst_we",    fifo_we,   0);
      chk("mid_rst_ready", s_ready,   0);
      chk("mid_rst_busy",  busy,      0);
      chk("mid_rst_count", pkt_count, 0);
      idle(2);
      rst = 1'b1;
      wr_log.delete();
      set_pay('{8'h33});
      d0 = done_seen;
      for (c = 0; c < 40 && done_seen == d0; c++) begin
         start = (c == 0); pkt_len = 8'd1; s_valid = 1'b1; fifo_full = 1'b0;
         step();
      end
      chk("post_rst_done", done_seen - d0, 1);
      idle(2);
      chk_log("post_rst", '{8'h01, 8'h33, 8'hCD});
      chk("post_rst_count", pkt_count, 1);

      // random traffic against the model
      pay.delete(); pidx = 0;
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 3) == 0);
         pkt_len   = ($urandom_range(0, 9) == 0) ? 8'd0 : LW'($urandom_range(1, 6));
         fifo_full = ($urandom_range(0, 9) < 3);
         s_valid   = ($urandom_range(0, 9) < 7);
         s_data    = DW'($urandom);
         rst       = ($urandom_range(0, 799) != 0);
         step();
      end
      rst = 1'b1;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
